// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the ALU result path.
// Used by the Y drain buffer, its interface and its result store.
package matrix_pkg;
  localparam int RES_W  = 18;
  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int OUT_W  = 32;
  localparam int VEC_W  = LANES * RES_W;
  localparam int ENT_W  = $clog2(DEPTH);
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/y_drain_buffer_if.sv
// ALU-side capture and readout-side stream of the Y drain buffer.
// slave = buffer side, master = ALU array / readout side.
interface y_drain_buffer_if;
  import matrix_pkg::*;

  logic             alu_valid;
  logic [VEC_W-1:0] alu_result;
  logic             alu_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport slave (
    input  alu_valid, alu_result, out_ready,
    output alu_ready, out_valid, out_data, out_last
  );

  modport master (
    output alu_valid, alu_result, out_ready,
    input  alu_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/y_result_store.sv
// DEPTH x VEC_W register file: one sync write port, one comb read port.
// Contents are not reset; they are always written before being read.
module y_result_store
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [ENT_W-1:0] waddr_i,
  input  logic [VEC_W-1:0] wdata_i,
  input  logic [ENT_W-1:0] raddr_i,
  output logic [VEC_W-1:0] rdata_o
);
  logic [VEC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/y_drain_buffer.sv
// Collects ALU result vectors per frame, then streams them out
// lane by lane as sign-extended words on a valid/ready port.
module y_drain_buffer
  import matrix_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         frame_len,
  y_drain_buffer_if.slave    bus,
  output logic               busy,
  output logic               done
);
  localparam logic [3:0]        DEPTH_L   = 4'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_e            state_q, state_d;
  logic [3:0]        len_q, len_d;
  logic [ENT_W-1:0]  wr_q, wr_d;
  logic [ENT_W-1:0]  rde_q, rde_d;
  logic [LANE_W-1:0] rdl_q, rdl_d;

  logic              wr_en;
  logic              last;
  logic [VEC_W-1:0]  rd_vec;
  logic [RES_W-1:0]  lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rde_q   <= '0;
      rdl_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rde_q   <= rde_d;
      rdl_q   <= rdl_d;
    end
  end

  assign last = (state_q == DRAIN)
             && (4'(rde_q) == len_q - 4'd1)
             && (rdl_q == LAST_LANE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rde_d   = rde_q;
    rdl_d   = rdl_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
          wr_d    = '0;
          state_d = (frame_len == 4'd0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.alu_valid) begin
          wr_d = wr_q + 1'b1;
          if (4'(wr_q) == len_q - 4'd1) begin
            state_d = DRAIN;
            rde_d   = '0;
            rdl_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          rdl_d = rdl_q + 1'b1;
          if (rdl_q == LAST_LANE) rde_d = rde_q + 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
    // abort wins over every same-cycle event, final handshake included
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      wr_d    = '0;
      rde_d   = '0;
      rdl_d   = '0;
    end
  end

  assign wr_en = (state_q == COLLECT) && bus.alu_valid && !abort;

  y_result_store u_store (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_q),
    .wdata_i (bus.alu_result),
    .raddr_i (rde_q),
    .rdata_o (rd_vec)
  );

  assign lane = rd_vec[rdl_q * RES_W +: RES_W];

  assign bus.alu_ready = (state_q == COLLECT);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = last;
  assign bus.out_data  = (state_q == DRAIN)
                       ? {{(OUT_W - RES_W){lane[RES_W-1]}}, lane}
                       : '0;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule
